// File: rtl/receiver_pkg.sv
// Shared definitions for the 8N1 serial receiver: FSM state encoding,
// frame constants and bit-timing helpers.
package receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    // Full bit period in clocks for a given bit-rate value.
    function automatic logic [15:0] period_of(input logic [15:0] rate);
        return rate + 16'd3;
    endfunction

    // Half bit period in clocks, used to land on the middle of the start bit.
    function automatic logic [15:0] half_of(input logic [15:0] rate);
        return period_of(rate) >> 1;
    endfunction

endpackage

// File: rtl/receiver_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line, plus a registered
// copy of the synchronised value so a clean falling-edge strobe is available.
module rx_sync
    import receiver_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic rx,
    output logic rxs,
    output logic fall
);

    logic meta;
    logic prev;

    // Synchroniser chain and previous-value register, all idling high like the line.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            meta <= 1'b1;
            rxs  <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            rxs  <= meta;
            prev <= rxs;
        end
    end

    assign fall = prev & ~rxs;

endmodule

// File: rtl/receiver.sv
// 8N1 serial byte receiver: finds the start bit, samples every bit at
// mid-period, holds good bytes with a level ready flag and pulses framing
// and overrun errors for one clock.
module receiver
    import receiver_pkg::*;
#(
    parameter logic [15:0] BIT_RATE_VAL = 16'h01B0
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       drdy,
    output logic       ferr,
    output logic       ovr
);

    localparam logic [15:0] PERIOD_LOAD = period_of(BIT_RATE_VAL) - 16'd1;
    localparam logic [15:0] HALF_LOAD   = half_of(BIT_RATE_VAL) - 16'd1;
    localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

    logic        rxs;
    logic        fall;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_nxt;
    logic [7:0]  shift;
    logic [7:0]  shift_nxt;
    logic [7:0]  dout_nxt;
    logic        drdy_nxt;
    logic        ferr_nxt;
    logic        ovr_nxt;
    logic        cnt_zero;

    rx_sync u_sync (
        .clk  (clk),
        .res  (res),
        .rx   (rx),
        .rxs  (rxs),
        .fall (fall)
    );

    assign cnt_zero = (cnt == 16'd0);

    // State, timing and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            dout    <= 8'h00;
            drdy    <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
            dout    <= dout_nxt;
            drdy    <= drdy_nxt;
            ferr    <= ferr_nxt;
            ovr     <= ovr_nxt;
        end
    end

    // Frame sequencing: counts down to each mid-bit sample point and decides what the sample means.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_zero ? cnt : cnt - 16'd1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        dout_nxt    = dout;
        drdy_nxt    = drdy & ~rd;
        ferr_nxt    = 1'b0;
        ovr_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (fall) begin
                    cnt_nxt   = HALF_LOAD;
                    state_nxt = START;
                end
            end

            START: begin
                if (cnt_zero) begin
                    if (rxs == 1'b0) begin
                        cnt_nxt     = PERIOD_LOAD;
                        bit_idx_nxt = 3'd0;
                        state_nxt   = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_zero) begin
                    shift_nxt = {rxs, shift[7:1]};
                    cnt_nxt   = PERIOD_LOAD;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end

            STOP: begin
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    if (rxs == STOP_LEVEL) begin
                        dout_nxt = shift;
                        drdy_nxt = 1'b1;
                        ovr_nxt  = drdy & ~rd;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for the 8N1 receiver at P=16, H=8: directed frame
// table plus hand-written sequences for timing, errors and reset.
module tb_receiver;

    logic       clk;
    logic       res;
    logic       rx;
    logic       rd;
    logic [7:0] dout;
    logic       drdy;
    logic       ferr;
    logic       ovr;

    int n_cmp;
    int n_err;
    int ferr_cnt;
    int ovr_cnt;
    int ferr0;
    int ovr0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd_start;
        logic       rd_stop;
        logic [7:0] exp_dout;
        logic       exp_drdy;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs [6];

    receiver #(.BIT_RATE_VAL(16'h000D)) dut (
        .clk  (clk),
        .res  (res),
        .rx   (rx),
        .rd   (rd),
        .dout (dout),
        .drdy (drdy),
        .ferr (ferr),
        .ovr  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count error pulses clock by clock; a pulse wider than one clock counts more than once.
    always @(negedge clk) begin
        if (ferr === 1'b1) ferr_cnt++;
        if (ovr === 1'b1) ovr_cnt++;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one full frame, 16 clocks per bit; optional read strobes in the
    // first clock of the frame or in the stop-sample completion clock.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop,
                                  input logic rd_start, input logic rd_stop);
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      rx = 1'b0;
            else if (b == 9) rx = stop;
            else             rx = data[b-1];
            for (int j = 0; j < 16; j++) begin
                rd = (rd_start && b == 0 && j == 0) || (rd_stop && b == 9 && j == 10);
                @(negedge clk);
            end
        end
        rd = 1'b0;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        logic [7:0] byte_v;
        n_cmp    = 0;
        n_err    = 0;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        res      = 1'b0;
        rx       = 1'b1;
        rd       = 1'b0;

        vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 0, 0};
        vecs[2] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 0, 1};
        vecs[4] = '{8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 0, 0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1, 0};

        // Reset held with a busy line
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rx = ~rx;
        end
        rx = 1'b1;
        @(negedge clk);
        check_output("reset dout", 32'(dout), 32'h00);
        check_output("reset drdy", 32'(drdy), 32'h0);
        check_output("reset ferr", 32'(ferr), 32'h0);
        check_output("reset ovr", 32'(ovr), 32'h0);
        res = 1'b1;
        repeat (30) @(negedge clk);
        check_output("idle drdy", 32'(drdy), 32'h0);

        // Single byte with exact completion timing
        byte_v = 8'hA5;
        ferr0  = ferr_cnt;
        ovr0   = ovr_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = byte_v[i];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check_output("A5 drdy before stop", 32'(drdy), 32'h0);
        @(negedge clk);
        check_output("A5 drdy after stop", 32'(drdy), 32'h1);
        check_output("A5 dout", 32'(dout), 32'hA5);
        repeat (5) @(negedge clk);
        pulse_rd();
        check_output("A5 drdy after rd", 32'(drdy), 32'h0);
        check_output("A5 no errors", 32'(ferr_cnt - ferr0 + ovr_cnt - ovr0), 32'h0);

        // Back-to-back frame table
        for (int i = 0; i < 6; i++) begin
            ferr0 = ferr_cnt;
            ovr0  = ovr_cnt;
            apply_stimulus(vecs[i].data, vecs[i].stop, vecs[i].rd_start, vecs[i].rd_stop);
            check_output($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check_output($sformatf("v%0d drdy", i), 32'(drdy), 32'(vecs[i].exp_drdy));
            check_output($sformatf("v%0d ferr", i), 32'(ferr_cnt - ferr0), 32'(vecs[i].exp_ferr));
            check_output($sformatf("v%0d ovr", i), 32'(ovr_cnt - ovr0), 32'(vecs[i].exp_ovr));
        end

        // Break: line stays low after the framing error
        ferr0 = ferr_cnt;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check_output("break ferr", 32'(ferr_cnt - ferr0), 32'h0);
        check_output("break dout", 32'(dout), 32'h33);
        check_output("break drdy", 32'(drdy), 32'h1);
        pulse_rd();
        check_output("read drdy", 32'(drdy), 32'h0);
        pulse_rd();
        check_output("idle rd drdy", 32'(drdy), 32'h0);
        check_output("idle rd dout", 32'(dout), 32'h33);

        // False start glitch
        ferr0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check_output("glitch drdy", 32'(drdy), 32'h0);
        check_output("glitch ferr", 32'(ferr_cnt - ferr0), 32'h0);
        apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b0);
        check_output("after glitch dout", 32'(dout), 32'h5A);
        check_output("after glitch drdy", 32'(drdy), 32'h1);

        // Reset in the middle of data bit 3
        byte_v = 8'h96;
        ferr0  = ferr_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = byte_v[i];
            repeat (16) @(negedge clk);
        end
        rx = byte_v[3];
        repeat (8) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check_output("midreset dout", 32'(dout), 32'h00);
        check_output("midreset drdy", 32'(drdy), 32'h0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b1;
        repeat (200) @(negedge clk);
        check_output("post reset drdy", 32'(drdy), 32'h0);
        check_output("post reset dout", 32'(dout), 32'h00);
        check_output("post reset ferr", 32'(ferr_cnt - ferr0), 32'h0);
        apply_stimulus(8'hC3, 1'b1, 1'b0, 1'b0);
        check_output("recovery dout", 32'(dout), 32'hC3);
        check_output("recovery drdy", 32'(drdy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
